// File: rtl/issue_queue_if.sv
// Issue queue bus: enqueue lanes and controls in, dequeue window and occupancy out.
// The master side is the decode/issue logic; the slave side is the queue itself.
interface issue_queue_if #(
  parameter int DEPTH = 8,
  parameter int DW    = 64
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          flush;
  logic          stall;
  logic [1:0]    enq_en;
  logic [DW-1:0] enq_data0;
  logic [DW-1:0] enq_data1;
  logic [1:0]    issue_cnt;
  logic [1:0]    deq_valid;
  logic [DW-1:0] deq_data0;
  logic [DW-1:0] deq_data1;
  logic          queue_of;
  logic [CW-1:0] count;

  modport master (
    output flush, stall, enq_en, enq_data0, enq_data1, issue_cnt,
    input  deq_valid, deq_data0, deq_data1, queue_of, count
  );

  modport slave (
    input  flush, stall, enq_en, enq_data0, enq_data1, issue_cnt,
    output deq_valid, deq_data0, deq_data1, queue_of, count
  );
endinterface

// File: rtl/issue_queue.sv
// Dual-lane circular issue queue: two enqueues and up to two dequeues per cycle.
// Optional macro ISSUE_QUEUE_BYPASS_EN forwards enqueue lanes straight to the outputs when empty.
module issue_queue #(
  parameter int DEPTH = 8,
  parameter int DW    = 64
) (
  input  logic        clk,
  input  logic        resetn,
  issue_queue_if.slave iq
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] headPtr;
  logic [AW-1:0] tailPtr;
  logic [CW-1:0] cnt;

  logic [AW-1:0] headPlus1;
  logic [AW-1:0] tailPlus1;
  logic          queueOf;
  logic          accept;
  logic [1:0]    enqNum;
  logic [1:0]    issueEff;
  logic [1:0]    deqNum;
  logic [1:0]    bypassNum;
  logic [1:0]    wrNum;
  logic [DW-1:0] wrData0;

  assign headPlus1 = headPtr + AW'(1);
  assign tailPlus1 = tailPtr + AW'(1);

  // Threshold looks only at the pre-edge count, so a same-cycle dequeue never opens room.
  assign queueOf  = cnt > CW'(DEPTH - 2);
  assign accept   = ~queueOf & ~iq.flush;
  assign enqNum   = accept ? ({1'b0, iq.enq_en[0]} + {1'b0, iq.enq_en[1]}) : 2'd0;
  assign issueEff = (iq.issue_cnt == 2'd3) ? 2'd2 : iq.issue_cnt;
  assign deqNum   = (iq.stall | iq.flush)     ? 2'd0 :
                    (cnt < CW'(issueEff))     ? cnt[1:0] : issueEff;

`ifdef ISSUE_QUEUE_BYPASS_EN
  logic bypassOn;
  assign bypassOn  = (cnt == '0) & ~iq.flush;
  // Lanes taken straight from the enqueue port never land in storage.
  assign bypassNum = (bypassOn & ~iq.stall) ? ((issueEff < enqNum) ? issueEff : enqNum) : 2'd0;
  assign iq.deq_valid = bypassOn ? iq.enq_en : {cnt >= CW'(2), cnt >= CW'(1)};
  assign iq.deq_data0 = bypassOn ? iq.enq_data0 : mem[headPtr];
  assign iq.deq_data1 = bypassOn ? iq.enq_data1 : mem[headPlus1];
`else
  assign bypassNum    = 2'd0;
  assign iq.deq_valid = {cnt >= CW'(2), cnt >= CW'(1)};
  assign iq.deq_data0 = mem[headPtr];
  assign iq.deq_data1 = mem[headPlus1];
`endif

  assign wrNum   = enqNum - bypassNum;
  assign wrData0 = (bypassNum == 2'd0) ? iq.enq_data0 : iq.enq_data1;

  assign iq.queue_of = queueOf;
  assign iq.count    = cnt;

  always_ff @(posedge clk) begin
    if (wrNum != 2'd0) mem[tailPtr]   <= wrData0;
    if (wrNum == 2'd2) mem[tailPlus1] <= iq.enq_data1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      headPtr <= '0;
      tailPtr <= '0;
      cnt     <= '0;
    end else if (iq.flush) begin
      headPtr <= '0;
      tailPtr <= '0;
      cnt     <= '0;
    end else begin
      headPtr <= headPtr + AW'(deqNum);
      tailPtr <= tailPtr + AW'(wrNum);
      cnt     <= cnt + CW'(wrNum) - CW'(deqNum);
    end
  end
endmodule

// File: tb/tb_issue_queue.sv
// Directed bench for issue_queue: reset, dual enqueue, stall, overflow guard, flush, wrap order.
module tb_issue_queue;
  localparam int DEPTH = 8;
  localparam int DW    = 64;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  issue_queue_if #(.DEPTH(DEPTH), .DW(DW)) iq ();
  issue_queue #(.DEPTH(DEPTH), .DW(DW)) dut (.clk(clk), .resetn(resetn), .iq(iq));

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] en, input logic [63:0] d0, input logic [63:0] d1,
                       input logic [1:0] ic, input logic st, input logic fl);
    iq.enq_en    = en;
    iq.enq_data0 = d0;
    iq.enq_data1 = d1;
    iq.issue_cnt = ic;
    iq.stall     = st;
    iq.flush     = fl;
  endtask

  task automatic idle();
    drive(2'b00, 64'h0, 64'h0, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn = 1'b0;
    idle();
    #12;
    chk("rst_count", iq.count, 0);
    chk("rst_valid", iq.deq_valid, 0);
    chk("rst_of", iq.queue_of, 0);

    // First edge after reset release accepts a dual enqueue.
    resetn = 1'b1;
    drive(2'b11, 64'hA, 64'hB, 2'd0, 1'b0, 1'b0);
    tick(); idle(); #1;
    chk("dual_count", iq.count, 2);
    chk("dual_valid", iq.deq_valid, 2'b11);
    chk("dual_d0", iq.deq_data0, 64'hA);
    chk("dual_d1", iq.deq_data1, 64'hB);
    chk("dual_of", iq.queue_of, 0);

    drive(2'b01, 64'hC, 64'h0, 2'd0, 1'b0, 1'b0);
    tick(); idle(); #1;
    chk("three_count", iq.count, 3);

    drive(2'b00, 64'h0, 64'h0, 2'd2, 1'b1, 1'b0);
    tick(); idle(); #1;
    chk("stall_count", iq.count, 3);
    chk("stall_head", iq.deq_data0, 64'hA);

    drive(2'b00, 64'h0, 64'h0, 2'd1, 1'b0, 1'b0);
    tick(); idle(); #1;
    chk("deq1_count", iq.count, 2);
    chk("deq1_d0", iq.deq_data0, 64'hB);
    chk("deq1_d1", iq.deq_data1, 64'hC);

    drive(2'b00, 64'h0, 64'h0, 2'd3, 1'b0, 1'b0);
    tick(); idle(); #1;
    chk("deq3_count", iq.count, 0);
    chk("deq3_valid", iq.deq_valid, 2'b00);

    drive(2'b01, 64'hE, 64'h0, 2'd0, 1'b0, 1'b0);
    tick(); idle(); #1;
    chk("one_count", iq.count, 1);
    chk("one_valid", iq.deq_valid, 2'b01);
    chk("one_d0", iq.deq_data0, 64'hE);

    drive(2'b00, 64'h0, 64'h0, 2'd2, 1'b0, 1'b0);
    tick(); idle(); #1;
    chk("min_count", iq.count, 0);

    // Fill to the overflow threshold.
    for (int i = 0; i < 3; i++) begin
      drive(2'b11, 64'h10 + 64'(2 * i), 64'h11 + 64'(2 * i), 2'd0, 1'b0, 1'b0);
      tick();
    end
    idle(); #1;
    chk("fill6_count", iq.count, 6);
    chk("fill6_of", iq.queue_of, 0);
    drive(2'b01, 64'h16, 64'h0, 2'd0, 1'b0, 1'b0);
    tick(); idle(); #1;
    chk("fill7_count", iq.count, 7);
    chk("fill7_of", iq.queue_of, 1);

    drive(2'b01, 64'h99, 64'h0, 2'd0, 1'b0, 1'b0);
    tick(); idle(); #1;
    chk("of_ignore_count", iq.count, 7);

    drive(2'b01, 64'h98, 64'h0, 2'd1, 1'b0, 1'b0);
    tick(); idle(); #1;
    chk("of_same_cycle_count", iq.count, 6);
    chk("of_same_cycle_d0", iq.deq_data0, 64'h11);
    chk("of_same_cycle_of", iq.queue_of, 0);

    drive(2'b00, 64'h0, 64'h0, 2'd1, 1'b0, 1'b0);
    tick(); idle(); #1;
    chk("five_count", iq.count, 5);
    chk("five_d0", iq.deq_data0, 64'h12);
    chk("five_d1", iq.deq_data1, 64'h13);

    drive(2'b11, 64'h55, 64'h66, 2'd0, 1'b0, 1'b1);
    tick(); idle(); #1;
    chk("flush_count", iq.count, 0);
    chk("flush_valid", iq.deq_valid, 2'b00);
    chk("flush_of", iq.queue_of, 0);

    // Twenty sequential tags, one in and one out per cycle, wrapping the pointers.
    for (int i = 0; i < 20; i++) begin
      if (i == 0) begin
        drive(2'b01, 64'h100, 64'h0, 2'd0, 1'b0, 1'b0);
      end else begin
        chk("wrap_order", iq.deq_data0, 64'h100 + 64'(i - 1));
        drive(2'b01, 64'h100 + 64'(i), 64'h0, 2'd1, 1'b0, 1'b0);
      end
      tick();
    end
    idle(); #1;
    chk("wrap_last", iq.deq_data0, 64'h113);
    chk("wrap_last_count", iq.count, 1);
    drive(2'b00, 64'h0, 64'h0, 2'd1, 1'b0, 1'b0);
    tick(); idle(); #1;
    chk("wrap_drain", iq.count, 0);

    drive(2'b11, 64'hC, 64'hD, 2'd1, 1'b0, 1'b0);
    #1;
`ifdef ISSUE_QUEUE_BYPASS_EN
    chk("byp_valid", iq.deq_valid, 2'b11);
    chk("byp_d0", iq.deq_data0, 64'hC);
    tick(); idle(); #1;
    chk("byp_count", iq.count, 1);
    chk("byp_next_d0", iq.deq_data0, 64'hD);
`else
    chk("lat_valid", iq.deq_valid, 2'b00);
    tick(); idle(); #1;
    chk("lat_count", iq.count, 2);
    chk("lat_d0", iq.deq_data0, 64'hC);
`endif

    // Asynchronous reset between edges.
    #1;
    resetn = 1'b0;
    #1;
    chk("async_rst_count", iq.count, 0);
    chk("async_rst_valid", iq.deq_valid, 2'b00);
    resetn = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
